// File: rtl/ttl_pkg.sv
// Shared types and helpers for the 74-section counter models.
// Provides the counter FSM state type, direction encodings and the load clamp.
// Imported by ttl_term_detect and ttl_counter_191.
package ttl_pkg;

  typedef enum logic {
    TTL_RUN  = 1'b0,
    TTL_HALT = 1'b1
  } ttl_cnt_state_t;

  localparam logic TTL_DIR_UP = 1'b0;
  localparam logic TTL_DIR_DN = 1'b1;

  // Load data at or beyond the modulus would leave the counter outside its
  // sequence, so it is pinned to the last legal value instead.
  function automatic int unsigned ttl_clamp(input int unsigned d,
                                            input int unsigned modulus);
    return (d >= modulus) ? (modulus - 1) : d;
  endfunction

endpackage

// File: rtl/ttl_term_detect.sv
// Combinational terminal-count compare for modulo counters.
// Ports: q/dn/ent in; at_term (Q at the terminal value for direction dn),
//        tc (at_term gated by the cascade enable ent) out.
module ttl_term_detect
  import ttl_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter logic [WIDTH-1:0] TERM_UP = '1
) (
  input  logic [WIDTH-1:0] q,
  input  logic             dn,
  input  logic             ent,
  output logic             at_term,
  output logic             tc
);

  assign at_term = (dn == TTL_DIR_DN) ? (q == '0) : (q == TERM_UP);
  assign tc      = ent & at_term;

endmodule

// File: rtl/ttl_counter_191.sv
// Synchronous up/down modulo counter with cascade enables, parallel load
// and one-shot halt. Ports: CLK, CLR (async, active-high), LD, ENP, ENT, DN,
// ONESHOT, D in; Q, TC (combinational), HALTED, OVF out.
// Optional sticky wrap flag OVF is built only when TTL_COUNTER_OVF_EN is defined.
module ttl_counter_191
  import ttl_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MODULUS = 16
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             LD,
  input  logic             ENP,
  input  logic             ENT,
  input  logic             DN,
  input  logic             ONESHOT,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             HALTED,
  output logic             OVF
);

  localparam logic [WIDTH-1:0] TERM_UP = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  ttl_cnt_state_t   state, state_next;
  logic [WIDTH-1:0] q_r, q_next;
  logic [WIDTH-1:0] load_val;
  logic             at_term;
  logic             count_en;
  logic             wrap;

  ttl_term_detect #(
    .WIDTH   (WIDTH),
    .TERM_UP (TERM_UP)
  ) u_term (
    .q       (q_r),
    .dn      (DN),
    .ent     (ENT),
    .at_term (at_term),
    .tc      (TC)
  );

  assign load_val = WIDTH'(ttl_clamp(32'(D), MODULUS));
  assign count_en = ENP & ENT & (state == TTL_RUN) & ~LD;

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state <= TTL_RUN;
      q_r   <= '0;
    end else begin
      state <= state_next;
      q_r   <= q_next;
    end
  end

  always_comb begin
    state_next = state;
    q_next     = q_r;
    wrap       = 1'b0;
    if (LD) begin
      q_next     = load_val;
      state_next = TTL_RUN;
    end else if (count_en) begin
      if (at_term && ONESHOT) begin
        // Halt instead of wrapping: Q parks on the terminal value.
        state_next = TTL_HALT;
      end else if (at_term) begin
        wrap   = 1'b1;
        q_next = (DN == TTL_DIR_DN) ? TERM_UP : '0;
      end else begin
        q_next = (DN == TTL_DIR_DN) ? (q_r - ONE) : (q_r + ONE);
      end
    end
  end

  assign Q      = q_r;
  assign HALTED = (state == TTL_HALT);

`ifdef TTL_COUNTER_OVF_EN
  logic ovf_r;

  // Load clears the flag even if the same edge would otherwise wrap.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR)       ovf_r <= 1'b0;
    else if (LD)   ovf_r <= 1'b0;
    else if (wrap) ovf_r <= 1'b1;
  end

  assign OVF = ovf_r;
`else
  assign OVF = 1'b0;
`endif

endmodule
